// File: rtl/add_exec_pipe.sv
// rtl/add_exec_pipe.sv - pipelined add/sub/logic execution unit with credit-guarded result FIFO
module add_exec_pipe #(
  parameter int DATA_W    = 8,
  parameter int ROB_W     = 3,
  parameter int REG_W     = 4,
  parameter int RS_W      = 3,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 2,
  localparam int CAP      = LATENCY + OUT_DEPTH,
  localparam int IF_W     = $clog2(CAP + 1)
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [ROB_W-1:0]  in_rob,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [RS_W-1:0]   in_rs_idx,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_carry,
  output logic              cdb_exc,
  output logic [ROB_W-1:0]  cdb_rob,
  output logic [REG_W-1:0]  cdb_rd,
  output logic [RS_W-1:0]   cdb_rs_idx,
  output logic [IF_W-1:0]   inflight
);

  localparam int ENT_W = DATA_W + 2 + ROB_W + REG_W + RS_W;
  localparam int PTR_W = $clog2(CAP);

  logic              clr;
  logic              accept;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   res;
  logic              exc;
  logic [ENT_W-1:0]  entry_in;
  logic [ENT_W-1:0]  head;

  logic [ENT_W-1:0]  pipe_q [LATENCY];
  logic [LATENCY-1:0] pipe_v;

  // The pipeline never stalls, so every ungranted result may end up parked
  // here at once; storage is sized for the full credit window.
  logic [ENT_W-1:0]  fifo_q [CAP];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IF_W-1:0]   fifo_cnt;

  assign clr      = rst | flush;
  assign in_ready = !rst && !flush && (inflight < IF_W'(CAP));
  assign accept   = in_valid && in_ready;
  assign push     = pipe_v[LATENCY-1];
  assign pop      = cdb_valid && cdb_ready;

  always_comb begin
    res = '0;
    exc = 1'b0;
    case (in_func)
      4'b0000: res = {1'b0, in_rs1} + {1'b0, in_rs2};
      4'b0001: res = {1'b0, in_rs1} - {1'b0, in_rs2};
      4'b0010: res = {1'b0, in_rs1 & in_rs2};
      4'b0011: res = {1'b0, in_rs1 | in_rs2};
      4'b0100: res = {1'b0, in_rs1 ^ in_rs2};
      4'b0101: res = {{DATA_W{1'b0}}, in_rs1 < in_rs2};
      default: exc = 1'b1;
    endcase
  end

  assign entry_in = {res[DATA_W-1:0], res[DATA_W], exc, in_rob, in_rd, in_rs_idx};

  always_ff @(posedge clk2) begin
    pipe_q[0] <= entry_in;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
    if (clr) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (push) begin
      fifo_q[wr_ptr] <= pipe_q[LATENCY-1];
    end
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(CAP - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(CAP - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (clr) begin
      inflight <= '0;
    end else if (accept && !pop) begin
      inflight <= inflight + 1'b1;
    end else if (pop && !accept) begin
      inflight <= inflight - 1'b1;
    end
  end

  // Outputs read as zero whenever nothing is queued, so stale entries never leak.
  assign cdb_valid = (fifo_cnt != '0);
  assign head      = cdb_valid ? fifo_q[rd_ptr] : '0;
  assign {cdb_data, cdb_carry, cdb_exc, cdb_rob, cdb_rd, cdb_rs_idx} = head;

endmodule

// File: tb/tb_add_exec_pipe.sv
// tb/tb_add_exec_pipe.sv - directed self-checking bench for add_exec_pipe
module tb_add_exec_pipe;

  logic       clk2;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_func;
  logic [7:0] in_rs1;
  logic [7:0] in_rs2;
  logic [2:0] in_rob;
  logic [3:0] in_rd;
  logic [2:0] in_rs_idx;
  logic       cdb_valid;
  logic       cdb_ready;
  logic [7:0] cdb_data;
  logic       cdb_carry;
  logic       cdb_exc;
  logic [2:0] cdb_rob;
  logic [3:0] cdb_rd;
  logic [2:0] cdb_rs_idx;
  logic [2:0] inflight;

  int total = 0;
  int bad   = 0;
  int seq   = 0;

  logic [7:0] exp_data_q [$];
  logic [2:0] exp_rob_q  [$];

  add_exec_pipe dut (
    .clk2       (clk2),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rob     (in_rob),
    .in_rd      (in_rd),
    .in_rs_idx  (in_rs_idx),
    .cdb_valid  (cdb_valid),
    .cdb_ready  (cdb_ready),
    .cdb_data   (cdb_data),
    .cdb_carry  (cdb_carry),
    .cdb_exc    (cdb_exc),
    .cdb_rob    (cdb_rob),
    .cdb_rd     (cdb_rd),
    .cdb_rs_idx (cdb_rs_idx),
    .inflight   (inflight)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ed, input logic ec,
                        input logic ee);
    logic [2:0] rob;
    logic [3:0] rd;
    logic [2:0] rsi;
    seq++;
    rob = 3'(seq);
    rd  = 4'(seq * 3);
    rsi = 3'(seq + 5);
    in_valid  = 1'b1;
    in_func   = f;
    in_rs1    = a;
    in_rs2    = b;
    in_rob    = rob;
    in_rd     = rd;
    in_rs_idx = rsi;
    cdb_ready = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, "_v1"}, cdb_valid, 0);
    step();
    check({tag, "_v2"}, cdb_valid, 0);
    step();
    check({tag, "_valid"}, cdb_valid, 1);
    check({tag, "_data"}, cdb_data, ed);
    check({tag, "_carry"}, cdb_carry, ec);
    check({tag, "_exc"}, cdb_exc, ee);
    check({tag, "_rob"}, cdb_rob, rob);
    check({tag, "_rd"}, cdb_rd, rd);
    check({tag, "_rsi"}, cdb_rs_idx, rsi);
    step();
    check({tag, "_after_v"}, cdb_valid, 0);
    check({tag, "_after_if"}, inflight, 0);
  endtask

  task automatic drain(input string tag);
    cdb_ready = 1'b1;
    for (int c = 0; c < 20 && exp_data_q.size() > 0; c++) begin
      if (cdb_valid) begin
        check({tag, "_data"}, cdb_data, exp_data_q.pop_front());
        check({tag, "_rob"}, cdb_rob, exp_rob_q.pop_front());
      end
      step();
    end
    check({tag, "_left"}, exp_data_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_func = 4'd0;
    in_rs1 = 8'd0; in_rs2 = 8'd0; in_rob = 3'd0; in_rd = 4'd0; in_rs_idx = 3'd0;
    cdb_ready = 1'b0;
    step();
    step();
    check("rst_rdy", in_ready, 0);
    check("rst_valid", cdb_valid, 0);
    check("rst_data", cdb_data, 0);
    check("rst_if", inflight, 0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", in_ready, 1);

    run_op("add",  4'b0000, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0);
    run_op("sub1", 4'b0001, 8'd5,   8'd7,   8'hFE,  1'b1, 1'b0);
    run_op("sub2", 4'b0001, 8'd7,   8'd5,   8'h02,  1'b0, 1'b0);
    run_op("sltu", 4'b0101, 8'd3,   8'd9,   8'd1,   1'b0, 1'b0);
    run_op("sltf", 4'b0101, 8'd9,   8'd3,   8'd0,   1'b0, 1'b0);
    run_op("and",  4'b0010, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0);
    run_op("or",   4'b0011, 8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0);
    run_op("xor",  4'b0100, 8'hAA,  8'hFF,  8'h55,  1'b0, 1'b0);
    run_op("ill",  4'b1111, 8'hFF,  8'hFF,  8'h00,  1'b0, 1'b1);

    // Backpressure: six issues against a four-entry credit window
    cdb_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_func  = 4'b0000;
      in_rs1   = 8'(k * 16 + 1);
      in_rs2   = 8'd2;
      in_rob   = 3'(k);
      check("bp_rdy", in_ready, (k < 4) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    check("bp_if", inflight, 4);
    check("bp_rdy_full", in_ready, 0);
    cdb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_out_v", cdb_valid, 1);
      check("bp_out_data", cdb_data, 8'(k * 16 + 3));
      check("bp_out_rob", cdb_rob, 3'(k));
      step();
      if (k == 0) check("bp_rdy_back", in_ready, 1);
    end
    check("bp_empty_v", cdb_valid, 0);
    check("bp_empty_if", inflight, 0);
    step();
    check("bp_noundf", inflight, 0);

    // Full boundary with simultaneous pop and issue
    cdb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_func  = 4'b0000;
      in_rs1   = 8'(40 + k);
      in_rs2   = 8'd1;
      in_rob   = 3'(k);
      exp_data_q.push_back(8'(41 + k));
      exp_rob_q.push_back(3'(k));
      check("fb_fill_rdy", in_ready, 1);
      step();
    end
    in_rs1 = 8'd99; in_rs2 = 8'd0; in_rob = 3'd7;
    cdb_ready = 1'b1;
    check("fb_if4", inflight, 4);
    check("fb_rdy_pop", in_ready, 0);
    check("fb_head_v", cdb_valid, 1);
    check("fb_head", cdb_data, exp_data_q.pop_front());
    void'(exp_rob_q.pop_front());
    step();
    check("fb_if3", inflight, 3);
    cdb_ready = 1'b0;
    check("fb_rdy_back", in_ready, 1);
    exp_data_q.push_back(8'd99);
    exp_rob_q.push_back(3'd7);
    step();
    in_valid = 1'b0;
    check("fb_if4b", inflight, 4);
    drain("fb_drain");

    // Flush with three operations in flight
    cdb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_func  = 4'b0000;
      in_rs1   = 8'(k);
      in_rs2   = 8'd5;
      in_rob   = 3'(k);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("fl_rdy", in_ready, 0);
    step();
    flush = 1'b0;
    check("fl_v", cdb_valid, 0);
    check("fl_if", inflight, 0);
    cdb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("fl_stale", cdb_valid, 0);
      step();
    end
    run_op("fl_add", 4'b0000, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);

    // Reset mid-stream
    cdb_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_func  = 4'b1111;
      in_rs1   = 8'hFF;
      in_rs2   = 8'hFF;
      in_rob   = 3'd6;
      in_rd    = 4'd9;
      in_rs_idx = 3'd4;
      step();
    end
    in_valid = 1'b0;
    step();
    check("mr_pre_v", cdb_valid, 1);
    check("mr_pre_exc", cdb_exc, 1);
    rst = 1'b1;
    #1;
    check("mr_rdy", in_ready, 0);
    step();
    check("mr_v", cdb_valid, 0);
    check("mr_data", cdb_data, 0);
    check("mr_carry", cdb_carry, 0);
    check("mr_exc", cdb_exc, 0);
    check("mr_rob", cdb_rob, 0);
    check("mr_rd", cdb_rd, 0);
    check("mr_rsi", cdb_rs_idx, 0);
    check("mr_if", inflight, 0);
    rst = 1'b0;
    step();
    check("mr_after_v", cdb_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_exec_pipe.md
# add_exec_pipe

Parametrised, pipelined add/sub/logic execution unit for the Tomasulo core. It is the successor to the fixed 8-bit, single-shot add execution unit. It accepts one issued operation per cycle from the add reservation stations and computes it in a fixed-latency pipeline. Results are buffered in an output FIFO until the common data bus (CDB) arbiter grants them. A credit counter guarantees the FIFO can never overflow, and a synchronous flush discards all in-flight work.

## Interface

Parameters:
- DATA_W, 8, operand/result width
- ROB_W, 3, ROB index width
- REG_W, 4, destination register index width
- RS_W, 3, reservation-station index width
- LATENCY, 2, pipeline stages (>=1)
- OUT_DEPTH, 2, output FIFO entries (>=1)
- CAP = LATENCY+OUT_DEPTH, derived, maximum in-flight operations

Ports:
- clk2  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all in-flight work
- in_valid  in  1  issue request from RS
- in_ready  out  1  unit can accept this cycle
- in_func  in  4  opcode
- in_rs1, in_rs2  in  DATA_W  operands
- in_rob  in  ROB_W  ROB tag
- in_rd  in  REG_W  destination register
- in_rs_idx  in  RS_W  originating RS entry
- cdb_valid  out  1  result available
- cdb_ready  in  1  CDB grant
- cdb_data  out  DATA_W  result
- cdb_carry  out  1  carry-out (add) / borrow (sub)
- cdb_exc  out  1  illegal opcode flag
- cdb_rob, cdb_rd, cdb_rs_idx  out  ROB_W/REG_W/RS_W  tags travelling with the result
- inflight  out  $clog2(CAP+1)  accepted but not yet granted operations

## Operation

- Accept occurs when in_valid && in_ready. The operation and its tags enter stage 1 and shift one stage per cycle, unconditionally. The pipeline never stalls.
- in_ready = !rst && !flush && (inflight < CAP). It is combinational and has no same-cycle bypass from a CDB pop.
- inflight: +1 on accept, −1 on cdb_valid && cdb_ready, unchanged when both happen together.
- After stage LATENCY, the result is written to the output FIFO tail. The credit rule guarantees the FIFO is never full at a write.
- FIFO head drives the cdb_* outputs. cdb_valid = FIFO not empty. The head pops on cdb_valid && cdb_ready. Results leave strictly in accept order.
- Results are computed on DATA_W+1 bits, with the low DATA_W bits going to cdb_data:
  - 4'b0000 ADD: rs1+rs2; carry = bit DATA_W.
  - 4'b0001 SUB: rs1−rs2 (two's complement wrap); carry = 1 if rs1<rs2 (unsigned).
  - 4'b0010 AND, 4'b0011 OR, 4'b0100 XOR: carry = 0.
  - 4'b0101 SLTU: data = 1 if rs1<rs2 unsigned, else 0; carry = 0.
  - Any other opcode: data = 0, carry = 0, exc = 1; the tags still flow normally.
- cdb_exc = 0 for all legal opcodes.
- flush or rst at an edge: all pipeline valid bits, FIFO pointers and inflight are cleared. Any same-cycle accept or pop is ignored. rst and flush have equal effect and priority over every other event.
- The RS frees entry cdb_rs_idx on a CDB handshake, not on accept.

## Timing

- Reset values: cdb_valid=0, cdb_data=0, cdb_carry=0, cdb_exc=0, all cdb tags 0, inflight=0, in_ready=0 while rst is high.
- Latency: an operation accepted at edge N is at the FIFO head after edge N+LATENCY. cdb_valid is therefore high in the cycle following edge N+LATENCY, provided all older results have already been granted.
- Throughput: one accept and one pop per cycle, sustained, when cdb_ready is held high.
- Full boundary: at inflight==CAP, in_ready=0 even if a pop happens in the same cycle. in_ready returns the cycle after the pop.
- Empty boundary: cdb_ready while cdb_valid=0 has no effect. inflight never underflows.
- Flush mid-operation: cdb_valid=0 in the cycle after the flush edge. An operation accepted on the cycle after the flush completes normally.

## Test plan

- Reset, then ADD 200+100 with cdb_ready=1 and LATENCY=2 → cdb_valid in the cycle after the second edge; data=8'd44, carry=1, exc=0, tags echoed.
- SUB 5−7 → data=8'hFE, carry=1. SUB 7−5 → data=8'h02, carry=0. SLTU 3,9 → data=1.
- cdb_ready=0, issue 6 back-to-back ops (CAP=4) → exactly 4 accepted, in_ready=0, inflight=4. Raise cdb_ready → 4 results in order on consecutive cycles, then in_ready reasserts.
- At inflight=CAP, pop and in_valid in the same cycle → no accept that cycle; accept on the next cycle; inflight goes 4→3→4.
- 3 ops in flight, assert flush one cycle → cdb_valid=0 and inflight=0 on the next cycle; no stale result ever appears. A fresh ADD 1+1 then returns 2.
- in_func=4'b1111 with rs1=rs2=8'hFF → data=0, carry=0, exc=1, tags intact. Assert rst mid-stream → all outputs return to their reset values on the next edge.
